// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole score sequencer.
package whack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_PLAY,
        ST_COOL,
        ST_OVER
    } state_t;

    localparam int         N_LANES_DEF      = 4;
    localparam int         GAME_SECONDS_DEF = 30;
    localparam logic [7:0] SCORE_MAX        = 8'd255;

endpackage

// File: rtl/score_sequencer_rr_arbiter.sv
// Round-robin lane picker: the search starts just after the last lane served.
module rr_arbiter
    import whack_pkg::*;
#(
    parameter int N_LANES = N_LANES_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_LANES-1:0] req,
    input  logic               advance,
    output logic [N_LANES-1:0] gnt
);

    localparam int PW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    logic [PW-1:0] last;
    logic [PW-1:0] pick;

    function automatic logic [PW-1:0] next_lane(input logic [N_LANES-1:0] r,
                                                input logic [PW-1:0]      from);
        logic [PW-1:0] sel;
        logic          found;
        sel   = from;
        found = 1'b0;
        for (int i = 1; i <= N_LANES; i++) begin
            int idx;
            idx = int'(from) + i;
            if (idx >= N_LANES) idx = idx - N_LANES;
            if (!found && r[PW'(idx)]) begin
                found = 1'b1;
                sel   = PW'(idx);
            end
        end
        return sel;
    endfunction

    assign pick = next_lane(req, last);

    always_comb begin
        gnt = '0;
        if (|req) gnt[pick] = 1'b1;
    end

    // Pointer resets to the top lane so lane 0 is searched first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last <= PW'(N_LANES - 1);
        else if (advance && |req) last <= pick;
    end

endmodule

// File: rtl/score_sequencer.sv
// Round sequencer: clears the score, serves hit/miss lanes round-robin with a
// two-cycle cooldown so the external counter settles, and times the round out.
module score_sequencer
    import whack_pkg::*;
#(
    parameter int N_LANES      = N_LANES_DEF,
    parameter int GAME_SECONDS = GAME_SECONDS_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               tick_1hz,
    input  logic [N_LANES-1:0] hit,
    input  logic [N_LANES-1:0] miss,
    input  logic [7:0]         count_in,
    output logic               clr,
    output logic               inc,
    output logic               dec,
    output logic [N_LANES-1:0] grant,
    output logic [7:0]         seconds_left,
    output logic               playing,
    output logic               game_over
);

    state_t             state, state_nxt;
    logic               cool_cnt, cool_nxt;
    logic [N_LANES-1:0] hit_pend, miss_pend, hit_nxt, miss_nxt;
    logic [N_LANES-1:0] arb_gnt, grant_nxt;
    logic [7:0]         sec_nxt;
    logic               clr_nxt, inc_nxt, dec_nxt;
    logic               in_round;

    assign in_round  = (state == ST_PLAY) || (state == ST_COOL);
    assign playing   = in_round;
    assign game_over = (state == ST_OVER);

    rr_arbiter #(.N_LANES(N_LANES)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (hit_pend | miss_pend),
        .advance (state == ST_PLAY),
        .gnt     (arb_gnt)
    );

    always_comb begin
        state_nxt = state;
        cool_nxt  = cool_cnt;
        sec_nxt   = seconds_left;
        hit_nxt   = hit_pend;
        miss_nxt  = miss_pend;
        clr_nxt   = 1'b0;
        inc_nxt   = 1'b0;
        dec_nxt   = 1'b0;
        grant_nxt = '0;
        case (state)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_nxt = ST_CLEAR;
                    sec_nxt   = 8'(GAME_SECONDS);
                    hit_nxt   = '0;
                    miss_nxt  = '0;
                    clr_nxt   = 1'b1;
                end
            end
            ST_CLEAR: state_nxt = ST_PLAY;
            ST_PLAY: begin
                if (|(hit_pend | miss_pend)) begin
                    grant_nxt = arb_gnt;
                    state_nxt = ST_COOL;
                    cool_nxt  = 1'b0;
                    // A hit outranks a miss on the same lane; saturated requests are dropped.
                    if (|(arb_gnt & hit_pend)) begin
                        inc_nxt = (count_in != SCORE_MAX);
                        hit_nxt = hit_pend & ~arb_gnt;
                    end else begin
                        dec_nxt  = (count_in != 8'd0);
                        miss_nxt = miss_pend & ~arb_gnt;
                    end
                end
            end
            ST_COOL: begin
                if (cool_cnt) state_nxt = ST_PLAY;
                else cool_nxt = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // New pulses are merged after service so a same-cycle set beats the clear.
        if (in_round || state == ST_CLEAR) begin
            hit_nxt  = hit_nxt | hit;
            miss_nxt = miss_nxt | (miss & ~hit);
        end

        if (in_round && tick_1hz) begin
            if (seconds_left <= 8'd1) begin
                sec_nxt   = 8'd0;
                state_nxt = ST_OVER;
                hit_nxt   = '0;
                miss_nxt  = '0;
            end else begin
                sec_nxt = seconds_left - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            cool_cnt     <= 1'b0;
            hit_pend     <= '0;
            miss_pend    <= '0;
            seconds_left <= 8'd0;
            clr          <= 1'b0;
            inc          <= 1'b0;
            dec          <= 1'b0;
            grant        <= '0;
        end else begin
            state        <= state_nxt;
            cool_cnt     <= cool_nxt;
            hit_pend     <= hit_nxt;
            miss_pend    <= miss_nxt;
            seconds_left <= sec_nxt;
            clr          <= clr_nxt;
            inc          <= inc_nxt;
            dec          <= dec_nxt;
            grant        <= grant_nxt;
        end
    end

endmodule

// File: tb/tb_score_sequencer.sv
// Bench for score_sequencer: directed round scenarios plus random play checked
// every cycle against a behavioural model of the game rules.
module tb_score_sequencer;

    localparam int NL = 4;
    localparam int GS = 30;
    localparam int M_IDLE = 0, M_CLEAR = 1, M_PLAY = 2, M_COOL = 3, M_OVER = 4;

    logic          clk = 1'b0;
    logic          reset, start, tick_1hz;
    logic [NL-1:0] hit, miss;
    logic [7:0]    count_in;
    logic          clr, inc, dec;
    logic [NL-1:0] grant;
    logic [7:0]    seconds_left;
    logic          playing, game_over;

    logic [7:0]    score;
    logic          ovr_en, nxt_ovr_en;
    logic [7:0]    ovr_val, nxt_ovr_val;

    int n_tests = 0;
    int n_fail  = 0;

    int            m_mode, m_last, m_sec, m_cool;
    bit            m_hp[NL];
    bit            m_mp[NL];
    logic [7:0]    m_score;
    bit            e_clr, e_inc, e_dec;
    logic [NL-1:0] e_grant;

    always #5 clk = ~clk;

    score_sequencer #(.N_LANES(NL), .GAME_SECONDS(GS)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .tick_1hz     (tick_1hz),
        .hit          (hit),
        .miss         (miss),
        .count_in     (count_in),
        .clr          (clr),
        .inc          (inc),
        .dec          (dec),
        .grant        (grant),
        .seconds_left (seconds_left),
        .playing      (playing),
        .game_over    (game_over)
    );

    assign count_in = ovr_en ? ovr_val : score;

    // External score counter driven by the sequencer's requests.
    always @(posedge clk or posedge reset) begin
        if (reset)    score <= 8'd0;
        else if (clr) score <= 8'd0;
        else if (inc) score <= score + 8'd1;
        else if (dec) score <= score - 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_last  = NL - 1;
        m_sec   = 0;
        m_cool  = 0;
        m_score = 8'd0;
        e_clr   = 1'b0;
        e_inc   = 1'b0;
        e_dec   = 1'b0;
        e_grant = '0;
        for (int i = 0; i < NL; i++) begin
            m_hp[i] = 1'b0;
            m_mp[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit st, input bit tk, input logic [NL-1:0] h,
                              input logic [NL-1:0] m, input logic [7:0] cnt);
        int  old;
        int  lane;
        bit  found;
        if (e_clr)      m_score = 8'd0;
        else if (e_inc) m_score = m_score + 8'd1;
        else if (e_dec) m_score = m_score - 8'd1;
        old     = m_mode;
        e_clr   = 1'b0;
        e_inc   = 1'b0;
        e_dec   = 1'b0;
        e_grant = '0;
        case (old)
            M_IDLE, M_OVER: if (st) begin
                m_mode = M_CLEAR;
                m_sec  = GS;
                e_clr  = 1'b1;
                for (int i = 0; i < NL; i++) begin
                    m_hp[i] = 1'b0;
                    m_mp[i] = 1'b0;
                end
            end
            M_CLEAR: m_mode = M_PLAY;
            M_PLAY: begin
                found = 1'b0;
                lane  = 0;
                for (int k = 1; k <= NL; k++) begin
                    int l;
                    l = (m_last + k) % NL;
                    if (!found && (m_hp[l] || m_mp[l])) begin
                        found = 1'b1;
                        lane  = l;
                    end
                end
                if (found) begin
                    e_grant = NL'(1) << lane;
                    m_last  = lane;
                    if (m_hp[lane]) begin
                        e_inc      = (cnt != 8'd255);
                        m_hp[lane] = 1'b0;
                    end else begin
                        e_dec      = (cnt != 8'd0);
                        m_mp[lane] = 1'b0;
                    end
                    m_mode = M_COOL;
                    m_cool = 2;
                end
            end
            M_COOL: begin
                m_cool--;
                if (m_cool == 0) m_mode = M_PLAY;
            end
            default: m_mode = M_IDLE;
        endcase
        if (old == M_CLEAR || old == M_PLAY || old == M_COOL) begin
            for (int i = 0; i < NL; i++) begin
                if (h[i])      m_hp[i] = 1'b1;
                else if (m[i]) m_mp[i] = 1'b1;
            end
        end
        if ((old == M_PLAY || old == M_COOL) && tk) begin
            m_sec--;
            if (m_sec <= 0) begin
                m_sec  = 0;
                m_mode = M_OVER;
                for (int i = 0; i < NL; i++) begin
                    m_hp[i] = 1'b0;
                    m_mp[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("clr", clr, e_clr);
        check("inc", inc, e_inc);
        check("dec", dec, e_dec);
        check("grant", grant, e_grant);
        check("seconds_left", seconds_left, m_sec);
        check("playing", playing, (m_mode == M_PLAY || m_mode == M_COOL));
        check("game_over", game_over, (m_mode == M_OVER));
        check("score", score, m_score);
    endtask

    task automatic step(input bit st, input bit tk, input logic [NL-1:0] h, input logic [NL-1:0] m);
        @(negedge clk);
        compare_all();
        ovr_en   = nxt_ovr_en;
        ovr_val  = nxt_ovr_val;
        start    = st;
        tick_1hz = tk;
        hit      = h;
        miss     = m;
        model_step(st, tk, h, m, ovr_en ? ovr_val : score);
    endtask

    task automatic do_reset();
        @(negedge clk);
        compare_all();
        reset    = 1'b1;
        start    = 1'b0;
        tick_1hz = 1'b0;
        hit      = '0;
        miss     = '0;
        model_reset();
        #1;
        check("rst_clr", clr, 0);
        check("rst_inc", inc, 0);
        check("rst_dec", dec, 0);
        check("rst_grant", grant, 0);
        check("rst_seconds", seconds_left, 0);
        check("rst_playing", playing, 0);
        check("rst_game_over", game_over, 0);
        @(negedge clk);
        compare_all();
        reset = 1'b0;
        model_step(1'b0, 1'b0, '0, '0, ovr_en ? ovr_val : score);
    endtask

    initial begin
        logic [NL-1:0] gq[$];
        int            cyc[$];
        int            n_inc, n_dec, n_gnt;
        logic [NL-1:0] rh, rm;

        reset = 1'b1; start = 1'b0; tick_1hz = 1'b0; hit = '0; miss = '0;
        ovr_en = 1'b0; ovr_val = 8'd0; nxt_ovr_en = 1'b0; nxt_ovr_val = 8'd0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        reset = 1'b0;
        model_step(1'b0, 1'b0, '0, '0, score);
        repeat (2) step(1'b0, 1'b0, '0, '0);

        // Start: one clr pulse, timer loaded, then playing.
        step(1'b1, 1'b0, '0, '0);
        @(posedge clk); #1;
        check("start_clr", clr, 1);
        check("start_seconds", seconds_left, GS);
        check("start_playing_low", playing, 0);
        step(1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        check("playing_after_clear", playing, 1);
        check("clr_one_cycle", clr, 0);

        // Hits on lanes 0,2,3 together are served in order, three cycles apart.
        step(1'b0, 1'b0, 4'b1101, '0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, '0, '0);
            @(posedge clk); #1;
            if (grant != '0) begin
                gq.push_back(grant);
                cyc.push_back(i);
            end
        end
        check("rr_grant_count", gq.size(), 3);
        if (gq.size() == 3) begin
            check("rr_first", gq[0], 4'b0001);
            check("rr_second", gq[1], 4'b0100);
            check("rr_third", gq[2], 4'b1000);
            check("rr_gap_a", cyc[1] - cyc[0], 3);
            check("rr_gap_b", cyc[2] - cyc[1], 3);
        end
        check("score_three", score, 3);

        // Saturation: full counter drops the hit, empty counter drops the miss.
        nxt_ovr_en = 1'b1; nxt_ovr_val = 8'd255;
        step(1'b0, 1'b0, 4'b0010, '0);
        n_gnt = 0; n_inc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, '0, '0);
            @(posedge clk); #1;
            if (grant == 4'b0010) n_gnt++;
            if (inc) n_inc++;
        end
        check("sat_hi_grant", n_gnt, 1);
        check("sat_hi_no_inc", n_inc, 0);
        nxt_ovr_val = 8'd0;
        step(1'b0, 1'b0, '0, 4'b0010);
        n_gnt = 0; n_dec = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, '0, '0);
            @(posedge clk); #1;
            if (grant == 4'b0010) n_gnt++;
            if (dec) n_dec++;
        end
        check("sat_lo_grant", n_gnt, 1);
        check("sat_lo_no_dec", n_dec, 0);
        nxt_ovr_en = 1'b0;

        // Hit and miss on one lane in the same cycle: the miss is discarded.
        step(1'b0, 1'b0, 4'b0100, 4'b0100);
        n_inc = 0; n_dec = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b0, '0, '0);
            @(posedge clk); #1;
            if (inc) n_inc++;
            if (dec) n_dec++;
        end
        check("hitmiss_one_inc", n_inc, 1);
        check("hitmiss_no_dec", n_dec, 0);

        // Round timeout, then ignored hits, then restart.
        repeat (GS) step(1'b0, 1'b1, '0, '0);
        @(posedge clk); #1;
        check("timeout_seconds", seconds_left, 0);
        check("timeout_over", game_over, 1);
        check("timeout_not_playing", playing, 0);
        step(1'b0, 1'b0, 4'b1111, '0);
        n_gnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, '0, '0);
            @(posedge clk); #1;
            if (grant != '0) n_gnt++;
        end
        check("over_no_grant", n_gnt, 0);
        step(1'b1, 1'b0, '0, '0);
        @(posedge clk); #1;
        check("restart_clr", clr, 1);
        check("restart_seconds", seconds_left, GS);
        check("restart_over_low", game_over, 0);

        // A grant coinciding with the final tick still issues its increment.
        step(1'b0, 1'b0, '0, '0);
        repeat (GS - 1) step(1'b0, 1'b1, '0, '0);
        step(1'b0, 1'b0, 4'b0001, '0);
        step(1'b0, 1'b1, '0, '0);
        @(posedge clk); #1;
        check("last_tick_grant", grant, 4'b0001);
        check("last_tick_inc", inc, 1);
        check("last_tick_over", game_over, 1);
        check("last_tick_seconds", seconds_left, 0);

        // Reset during cooldown with lanes still pending.
        step(1'b1, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0);
        step(1'b0, 1'b0, 4'b1111, '0);
        step(1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        check("cool_before_reset", playing, 1);
        do_reset();
        n_gnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0, '0);
            @(posedge clk); #1;
            if (grant != '0) n_gnt++;
        end
        check("post_reset_no_grant", n_gnt, 0);

        // Random play against the model.
        step(1'b1, 1'b0, '0, '0);
        for (int c = 0; c < 2000; c++) begin
            for (int l = 0; l < NL; l++) begin
                rh[l] = ($urandom_range(0, 5) == 0);
                rm[l] = ($urandom_range(0, 5) == 0);
            end
            if ($urandom_range(0, 39) == 0) begin
                nxt_ovr_en  = 1'($urandom_range(0, 1));
                nxt_ovr_val = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0;
            end
            if ($urandom_range(0, 599) == 0)
                do_reset();
            else
                step(($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0), rh, rm);
        end

        @(negedge clk);
        compare_all();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/score_sequencer.md
SCORE_SEQUENCER -- requirements
Module: score_sequencer

Interface
REQ-001 Parameter N_LANES, default 4: number of mole holes (hit/miss requesters).
REQ-002 Parameter GAME_SECONDS, default 30: round length in tick_1hz pulses, range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse; begins a round.
REQ-006 tick_1hz  input  1  one-cycle pulse, once per second.
REQ-007 hit  input  N_LANES  per-lane one-cycle hit pulses.
REQ-008 miss  input  N_LANES  per-lane one-cycle miss pulses.
REQ-009 count_in  input  8  current score from the score counter.
REQ-010 clr  output  1  score counter reset request.
REQ-011 inc  output  1  score counter increment pulse.
REQ-012 dec  output  1  score counter decrement pulse.
REQ-013 grant  output  N_LANES  one-hot lane served this cycle; zero when idle.
REQ-014 seconds_left  output  8  remaining round time.
REQ-015 playing  output  1  high in PLAY/COOL states.
REQ-016 game_over  output  1  high in OVER state.

Function
REQ-017 FSM states: IDLE, CLEAR, PLAY, COOL, OVER.
REQ-018 IDLE/OVER + start -> CLEAR; other inputs ignored in IDLE/OVER.
REQ-019 CLEAR lasts exactly one cycle: clr=1, seconds_left loaded with GAME_SECONDS, all pending flags cleared; next state PLAY.
REQ-020 Per lane, hit_pend/miss_pend set on hit/miss pulse in CLEAR-exit, PLAY or COOL; a set in the same cycle as a service clear of that lane wins.
REQ-021 Same-cycle hit and miss on one lane: hit_pend set, miss discarded.
REQ-022 PLAY with any pending lane: round-robin pick starting after last granted lane (reset pointer: lane 0 has priority); grant one-hot for one cycle.
REQ-023 Served lane: hit_pend -> inc=1 unless count_in==255; else miss_pend -> dec=1 unless count_in==0; serviced flag cleared even when saturated (request dropped).
REQ-024 inc, dec, clr, grant are registered outputs, each high for exactly one cycle per event; inc and dec never high together.
REQ-025 After any grant, state COOL for 2 cycles, then PLAY; guarantees count_in reflects the prior op before the next check (max one op per 3 cycles).
REQ-026 tick_1hz in PLAY/COOL decrements seconds_left; tick when seconds_left==1 -> seconds_left=0, state OVER next cycle, all pending flags cleared, no further grants.
REQ-027 A grant in the same cycle as the terminating tick still issues its inc/dec.
REQ-028 start during PLAY/COOL ignored.
REQ-029 seconds_left holds value in OVER; restarted only via CLEAR.

Reset
REQ-030 Reset asserted: state IDLE; clr/inc/dec/playing/game_over=0; grant=0; seconds_left=0; pending flags=0; RR pointer=lane 0; takes effect immediately, including mid-round.
REQ-031 First cycle after reset release: outputs unchanged until start.

Structure
REQ-032 Shared package whack_pkg holds FSM state enum, N_LANES default, GAME_SECONDS default, SCORE_MAX=255.
REQ-033 One sub-module rr_arbiter (N_LANES-wide request, one-hot grant, pointer update on grant).

Verification
REQ-034 Reset, start -> clr=1 one cycle, seconds_left=30, playing=1 next cycle.
REQ-035 hit on lanes 0,2,3 same cycle -> grants 0,2,3 in order, 3 cycles apart, three inc pulses, score 3.
REQ-036 count_in=255, hit lane1 -> grant lane1, no inc; count_in=0, miss lane1 -> no dec.
REQ-037 hit+miss lane2 same cycle -> exactly one inc, no dec.
REQ-038 30 ticks -> seconds_left 0, game_over=1, later hits produce no grant; start -> CLEAR, seconds_left=30.
REQ-039 reset asserted mid-COOL with pending lanes -> outputs zero immediately, no grants after release.
